fft_stream_responder: RTL and testbench

// AXI-Stream responder that stands in for the vendor FFT core on the far side of fft_controller.

---
 rtl/fft_stream_responder_if.sv | 31 +++
 rtl/fft_stream_responder.sv | 82 ++++++++
 tb/tb_fft_stream_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_responder_if.sv
// fft_stream_responder_if: config, input-sample and output-sample AXI-Stream channels plus the framing event pulses
interface fft_stream_responder_if #(
  parameter int DATA_WIDTH = 24,
  parameter int OUTPUT_WIDTH = 32
);
  logic [7:0] s_axis_config_tdata;
  logic s_axis_config_tvalid;
  logic s_axis_config_tready;
  logic [2*DATA_WIDTH-1:0] s_axis_data_tdata;
  logic s_axis_data_tvalid;
  logic s_axis_data_tready;
  logic s_axis_data_tlast;
  logic [2*OUTPUT_WIDTH-1:0] m_axis_data_tdata;
  logic m_axis_data_tvalid;
  logic m_axis_data_tready;
  logic m_axis_data_tlast;
  logic event_tlast_unexpected;
  logic event_tlast_missing;
  modport master (
    output s_axis_config_tdata, s_axis_config_tvalid, s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    output m_axis_data_tready,
    input s_axis_config_tready, s_axis_data_tready, m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
    input event_tlast_unexpected, event_tlast_missing
  );
  modport slave (
    input s_axis_config_tdata, s_axis_config_tvalid, s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    input m_axis_data_tready,
    output s_axis_config_tready, s_axis_data_tready, m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
    output event_tlast_unexpected, event_tlast_missing
  );
endinterface

// File: rtl/fft_stream_responder.sv
// fft_stream_responder: buffers one frame, then streams it back sign-extended with imag negated on inverse frames
module fft_stream_responder #(
  parameter int FFT_POINTS = 16,
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_POINTS = $clog2(FFT_POINTS),
  parameter int OUTPUT_WIDTH = ((DATA_WIDTH + LOG2_POINTS + 8) / 8) * 8
) (
  input logic clk,
  input logic reset,
  fft_stream_responder_if.slave bus
);
  typedef enum logic {LOAD, DRAIN} state_t;
  localparam logic [LOG2_POINTS-1:0] LAST = LOG2_POINTS'(FFT_POINTS - 1);
  state_t state_q, state_d;
  logic [LOG2_POINTS-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic dir_q, dir_d, frame_dir_q, frame_dir_d;
  logic s_tready_q, s_tready_d, cfg_tready_q, cfg_tready_d;
  logic m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic ev_unexp_q, ev_unexp_d, ev_miss_q, ev_miss_d;
  logic [2*DATA_WIDTH-1:0] buf_q [FFT_POINTS];
  logic in_hs, out_hs, cfg_hs, unused_cfg;
  logic [DATA_WIDTH-1:0] rd_re, rd_im;
  logic [OUTPUT_WIDTH-1:0] ext_re, ext_im;
  assign in_hs = bus.s_axis_data_tvalid & s_tready_q;
  assign out_hs = m_tvalid_q & bus.m_axis_data_tready;
  assign cfg_hs = bus.s_axis_config_tvalid & cfg_tready_q;
  assign unused_cfg = ^bus.s_axis_config_tdata[7:1];
  always_comb begin
    dir_d = cfg_hs ? bus.s_axis_config_tdata[0] : dir_q;
    frame_dir_d = (in_hs && wr_idx_q == '0) ? dir_d : frame_dir_q;
    wr_idx_d = in_hs ? wr_idx_q + 1'b1 : wr_idx_q;
    rd_idx_d = out_hs ? rd_idx_q + 1'b1 : rd_idx_q;
    state_d = (in_hs && wr_idx_q == LAST) ? DRAIN : (out_hs && m_tlast_q) ? LOAD : state_q;
    s_tready_d = state_d == LOAD;
    cfg_tready_d = state_d == LOAD && wr_idx_d == '0;
    m_tvalid_d = state_d == DRAIN;
    m_tlast_d = state_d == DRAIN && rd_idx_d == LAST;
    ev_unexp_d = in_hs && bus.s_axis_data_tlast && wr_idx_q != LAST;
    ev_miss_d = in_hs && !bus.s_axis_data_tlast && wr_idx_q == LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      dir_q <= 1'b1;
      frame_dir_q <= 1'b1;
      s_tready_q <= 1'b0;
      cfg_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q <= 1'b0;
      ev_unexp_q <= 1'b0;
      ev_miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      dir_q <= dir_d;
      frame_dir_q <= frame_dir_d;
      s_tready_q <= s_tready_d;
      cfg_tready_q <= cfg_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q <= m_tlast_d;
      ev_unexp_q <= ev_unexp_d;
      ev_miss_q <= ev_miss_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_hs) buf_q[wr_idx_q] <= bus.s_axis_data_tdata;
  end
  // Output data is read straight from the buffer so it holds steady while the sink stalls
  assign {rd_im, rd_re} = buf_q[rd_idx_q];
  assign ext_re = {{(OUTPUT_WIDTH-DATA_WIDTH){rd_re[DATA_WIDTH-1]}}, rd_re};
  assign ext_im = {{(OUTPUT_WIDTH-DATA_WIDTH){rd_im[DATA_WIDTH-1]}}, rd_im};
  assign bus.m_axis_data_tdata = {frame_dir_q ? ext_im : -ext_im, ext_re};
  assign bus.s_axis_data_tready = s_tready_q;
  assign bus.s_axis_config_tready = cfg_tready_q;
  assign bus.m_axis_data_tvalid = m_tvalid_q;
  assign bus.m_axis_data_tlast = m_tlast_q;
  assign bus.event_tlast_unexpected = ev_unexp_q;
  assign bus.event_tlast_missing = ev_miss_q;
endmodule

// File: tb/tb_fft_stream_responder.sv
// tb_fft_stream_responder: random frames against a frame-level reference model, checked by a negedge scoreboard monitor
module tb_fft_stream_responder;
  localparam int N = 16;
  localparam int DW = 24;
  localparam int OW = 32;
  typedef struct packed {
    logic [2*OW-1:0] d;
    logic l;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fft_stream_responder_if #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) bus();
  fft_stream_responder #(.FFT_POINTS(N), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial forever #5 clk = ~clk;
  exp_t q[$];
  exp_t frame[$];
  exp_t e;
  int vectors = 0;
  int errs = 0;
  int in_cnt = 0;
  bit dir = 1'b1;
  bit fdir = 1'b1;
  bit pend_u = 1'b0;
  bit pend_m = 1'b0;
  bit rst_prev = 1'b0;
  bit held_v = 1'b0;
  bit cfg_hs;
  bit rnd_ready = 1'b0;
  logic [2*OW-1:0] held_d;
  logic held_l;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Expected output word: both halves sign-extended, imag negated for inverse frames
  function automatic logic [2*OW-1:0] model(logic [2*DW-1:0] s, bit fwd);
    longint re, im;
    re = longint'($signed(s[DW-1:0]));
    im = longint'($signed(s[2*DW-1:DW]));
    if (!fwd) im = -im;
    return {im[OW-1:0], re[OW-1:0]};
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      if (rst_prev) begin
        chk("rst_data_tready", bus.s_axis_data_tready, 0);
        chk("rst_cfg_tready", bus.s_axis_config_tready, 0);
        chk("rst_m_tvalid", bus.m_axis_data_tvalid, 0);
        chk("rst_m_tlast", bus.m_axis_data_tlast, 0);
        chk("rst_events", {bus.event_tlast_unexpected, bus.event_tlast_missing}, 0);
      end
      q.delete();
      frame.delete();
      in_cnt = 0;
      dir = 1'b1;
      pend_u = 1'b0;
      pend_m = 1'b0;
      held_v = 1'b0;
    end else if (!rst_prev) begin
      chk("cfg_tready", bus.s_axis_config_tready, in_cnt == 0 && q.size() == 0);
      chk("data_tready", bus.s_axis_data_tready, q.size() == 0);
      chk("m_tvalid", bus.m_axis_data_tvalid, q.size() != 0);
      chk("ev_unexpected", bus.event_tlast_unexpected, pend_u);
      chk("ev_missing", bus.event_tlast_missing, pend_m);
      if (held_v) begin
        chk("stall_tdata", bus.m_axis_data_tdata, held_d);
        chk("stall_tlast", bus.m_axis_data_tlast, held_l);
      end
      held_v = bus.m_axis_data_tvalid && !bus.m_axis_data_tready;
      held_d = bus.m_axis_data_tdata;
      held_l = bus.m_axis_data_tlast;
      if (bus.m_axis_data_tvalid && bus.m_axis_data_tready && q.size() != 0) begin
        e = q.pop_front();
        chk("out_tdata", bus.m_axis_data_tdata, e.d);
        chk("out_tlast", bus.m_axis_data_tlast, e.l);
      end
      cfg_hs = bus.s_axis_config_tvalid && bus.s_axis_config_tready;
      pend_u = 1'b0;
      pend_m = 1'b0;
      if (bus.s_axis_data_tvalid && bus.s_axis_data_tready) begin
        if (in_cnt == 0) fdir = cfg_hs ? bus.s_axis_config_tdata[0] : dir;
        e.d = model(bus.s_axis_data_tdata, fdir);
        e.l = in_cnt == N - 1;
        frame.push_back(e);
        pend_u = bus.s_axis_data_tlast && in_cnt < N - 1;
        pend_m = !bus.s_axis_data_tlast && in_cnt == N - 1;
        in_cnt++;
        if (in_cnt == N) begin
          foreach (frame[k]) q.push_back(frame[k]);
          frame.delete();
          in_cnt = 0;
        end
      end
      if (cfg_hs) dir = bus.s_axis_config_tdata[0];
    end
    rst_prev = reset;
  end
  initial begin
    bus.m_axis_data_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.m_axis_data_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  task automatic send_sample(logic [2*DW-1:0] d, bit l);
    int t = 0;
    @(posedge clk);
    #1;
    bus.s_axis_data_tvalid = 1'b1;
    bus.s_axis_data_tdata = d;
    bus.s_axis_data_tlast = l;
    do begin
      @(negedge clk);
      if (++t > 2000) begin
        $display("FAIL data_tready_timeout: no tready within %0d cycles", t);
        $fatal(1);
      end
    end while (!bus.s_axis_data_tready);
  endtask
  task automatic send_frame(int n, int last_at, int mode);
    for (int i = 0; i < n; i++) begin
      logic [2*DW-1:0] d;
      d = (mode == 0) ? {24'd0, 24'(i)} : {24'($urandom), 24'($urandom)};
      if (mode == 2 && i == 3) d[2*DW-1:DW] = 24'h800000;
      send_sample(d, i == last_at);
    end
    @(posedge clk);
    #1;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tlast = 1'b0;
  endtask
  task automatic send_cfg(logic [7:0] d);
    int t = 0;
    @(posedge clk);
    #1;
    bus.s_axis_config_tvalid = 1'b1;
    bus.s_axis_config_tdata = d;
    do begin
      @(negedge clk);
      if (++t > 2000) begin
        $display("FAIL cfg_tready_timeout: no tready within %0d cycles", t);
        $fatal(1);
      end
    end while (!bus.s_axis_config_tready);
    @(posedge clk);
    #1 bus.s_axis_config_tvalid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 || in_cnt != 0 || bus.m_axis_data_tvalid) begin
      @(negedge clk);
      if (++t > 2000) begin
        $display("FAIL drain_timeout: %0d outputs still pending", q.size());
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.s_axis_config_tvalid = 1'b0;
    bus.s_axis_config_tdata = 8'h00;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata = '0;
    bus.s_axis_data_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    send_cfg(8'h01);
    send_frame(N, N - 1, 0);
    wait_idle();
    send_cfg(8'h00);
    send_frame(N, N - 1, 2);
    wait_idle();
    rnd_ready = 1'b1;
    send_cfg(8'h01);
    send_frame(N, N - 1, 0);
    wait_idle();
    repeat (3) send_frame(N, N - 1, 1);
    wait_idle();
    send_frame(N, 7, 1);
    wait_idle();
    fork
      send_frame(N, N - 1, 1);
      begin
        repeat (4) @(posedge clk);
        send_cfg(8'hFE);
      end
    join
    send_frame(N, N - 1, 1);
    wait_idle();
    fork
      send_cfg(8'h03);
      send_frame(N, N - 1, 1);
    join
    wait_idle();
    send_frame(9, N - 1, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    send_frame(N, N - 1, 1);
    wait_idle();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
